// File: rtl/wb_txn_monitor.sv
// wb_txn_monitor: passive Wishbone B3 monitor. Captures every acknowledged beat
// into a first-word-fall-through FIFO, counts reads/writes and flags sticky
// protocol errors (ack timeout, unstable request, stb without cyc / bad cti,
// capture overflow).
// Optional build macro WB_MON_BURST_ADDR_CHECK_EN: checks that incrementing
// burst beats advance by DW/8 bytes and reports violations on err_proto.
module wb_txn_monitor #(
   parameter int APP_AW  = 26,
   parameter int DW      = 32,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 256
) (
   input  logic              wb_clk,
   input  logic              wb_rst,
   input  logic              wb_cyc,
   input  logic              wb_stb,
   input  logic              wb_we,
   input  logic [APP_AW-1:0] wb_addr,
   input  logic [DW/8-1:0]   wb_sel,
   input  logic [DW-1:0]     wb_dati,
   input  logic [DW-1:0]     wb_dato,
   input  logic              wb_ack,
   input  logic [2:0]        wb_cti,
   output logic              txn_valid,
   input  logic              txn_ready,
   output logic [APP_AW-1:0] txn_addr,
   output logic              txn_we,
   output logic [DW/8-1:0]   txn_sel,
   output logic [DW-1:0]     txn_data,
   output logic              txn_last,
   output logic [CNT_W-1:0]  rd_count,
   output logic [CNT_W-1:0]  wr_count,
   input  logic              err_clr,
   output logic              err_timeout,
   output logic              err_stable,
   output logic              err_proto,
   output logic              err_overflow
);
   localparam int SW = DW / 8;
   localparam int PW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BURST} state_t;

   typedef struct packed {
      logic [APP_AW-1:0] addr;
      logic              we;
      logic [SW-1:0]     sel;
      logic [DW-1:0]     data;
      logic              last;
   } entry_t;

   state_t            state_q, state_d;
   entry_t            mem_q [DEPTH];
   entry_t            entry_d;
   entry_t            head;
   logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              err_timeout_q, err_timeout_d, err_stable_q, err_stable_d;
   logic              err_proto_q, err_proto_d, err_overflow_q, err_overflow_d;
   logic [APP_AW-1:0] req_addr_q, req_addr_d;
   logic              req_we_q, req_we_d;
   logic [SW-1:0]     req_sel_q, req_sel_d;
   logic [DW-1:0]     req_dati_q, req_dati_d;
   logic              beat, wait_ack, empty, full, pop, push, drop;
   logic              req_changed, burst_addr_bad;
   logic              ev_timeout, ev_stable, ev_proto, ev_overflow;

`ifdef WB_MON_BURST_ADDR_CHECK_EN
   logic [APP_AW-1:0] prev_addr_q, prev_addr_d;

   // Track the last beat address so each burst beat can be checked against it.
   always_comb begin
      prev_addr_d    = prev_addr_q;
      burst_addr_bad = 1'b0;
      if (beat) begin
         prev_addr_d = wb_addr;
         if (state_q == ST_BURST && wb_addr != prev_addr_q + APP_AW'(SW))
            burst_addr_bad = 1'b1;
      end
   end

   // Previous-address register; pure datapath, no reset needed.
   always_ff @(posedge wb_clk) begin
      prev_addr_q <= prev_addr_d;
   end
`else
   assign burst_addr_bad = 1'b0;
`endif

   assign beat     = wb_cyc & wb_stb & wb_ack;
   assign wait_ack = wb_cyc & wb_stb & ~wb_ack;
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
   assign pop      = txn_ready & ~empty;
   assign push     = beat & (~full | pop);
   assign drop     = beat & full & ~pop;
   assign head     = mem_q[rd_ptr_q[PW-1:0]];

   // Head of the FIFO is presented directly; outputs read as zero when empty.
   assign txn_valid    = ~empty;
   assign txn_addr     = empty ? '0 : head.addr;
   assign txn_we       = ~empty & head.we;
   assign txn_sel      = empty ? '0 : head.sel;
   assign txn_data     = empty ? '0 : head.data;
   assign txn_last     = ~empty & head.last;
   assign rd_count     = rd_cnt_q;
   assign wr_count     = wr_cnt_q;
   assign err_timeout  = err_timeout_q;
   assign err_stable   = err_stable_q;
   assign err_proto    = err_proto_q;
   assign err_overflow = err_overflow_q;

   // Bus FSM: next state and the captured-beat record.
   always_comb begin
      state_d      = state_q;
      entry_d.addr = wb_addr;
      entry_d.we   = wb_we;
      entry_d.sel  = wb_sel;
      entry_d.data = wb_we ? wb_dati : wb_dato;
      // Anything other than an incrementing-burst continuation closes the transfer.
      entry_d.last = (wb_cti != CTI_INCR);
      if (!wb_cyc) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (beat)          state_d = (wb_cti == CTI_INCR) ? ST_BURST : ST_IDLE;
               else if (wait_ack) state_d = ST_REQ;
            end
            ST_REQ: begin
               if (beat)         state_d = (wb_cti == CTI_INCR) ? ST_BURST : ST_IDLE;
               else if (!wb_stb) state_d = ST_IDLE;
            end
            ST_BURST: begin
               if (beat) state_d = (wb_cti == CTI_INCR) ? ST_BURST : ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FIFO pointers, saturating counters, timeout counter and error detection.
   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      rd_cnt_d   = rd_cnt_q;
      wr_cnt_d   = wr_cnt_q;
      tmo_d      = '0;
      ev_timeout = 1'b0;
      if (beat && !wb_we && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
      if (beat &&  wb_we && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
      if (wait_ack) begin
         if (tmo_q == TW'(TIMEOUT - 1)) begin
            tmo_d      = tmo_q;
            ev_timeout = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
      req_changed = (wb_addr != req_addr_q) || (wb_we != req_we_q) || (wb_sel != req_sel_q) ||
                    (req_we_q && wb_dati != req_dati_q);
      ev_stable   = (state_q == ST_REQ) && wb_cyc && wb_stb && req_changed;
      ev_proto    = (wb_stb && !wb_cyc) ||
                    (beat && wb_cti != CTI_CLASSIC && wb_cti != CTI_INCR && wb_cti != CTI_END) ||
                    burst_addr_bad;
      ev_overflow = drop;
      // A new error event in the same cycle as err_clr keeps the flag set.
      err_timeout_d  = ev_timeout  | (err_timeout_q  & ~err_clr);
      err_stable_d   = ev_stable   | (err_stable_q   & ~err_clr);
      err_proto_d    = ev_proto    | (err_proto_q    & ~err_clr);
      err_overflow_d = ev_overflow | (err_overflow_q & ~err_clr);
      // Request snapshot taken when a request starts waiting for ack.
      req_addr_d = req_addr_q;
      req_we_d   = req_we_q;
      req_sel_d  = req_sel_q;
      req_dati_d = req_dati_q;
      if (state_q == ST_IDLE && wait_ack) begin
         req_addr_d = wb_addr;
         req_we_d   = wb_we;
         req_sel_d  = wb_sel;
         req_dati_d = wb_dati;
      end
   end

   // Control state with synchronous reset.
   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q        <= ST_IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         rd_cnt_q       <= '0;
         wr_cnt_q       <= '0;
         tmo_q          <= '0;
         err_timeout_q  <= 1'b0;
         err_stable_q   <= 1'b0;
         err_proto_q    <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         rd_cnt_q       <= rd_cnt_d;
         wr_cnt_q       <= wr_cnt_d;
         tmo_q          <= tmo_d;
         err_timeout_q  <= err_timeout_d;
         err_stable_q   <= err_stable_d;
         err_proto_q    <= err_proto_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   // Datapath storage: capture FIFO and request snapshot, not reset.
   always_ff @(posedge wb_clk) begin
      if (push && !wb_rst) mem_q[wr_ptr_q[PW-1:0]] <= entry_d;
      req_addr_q <= req_addr_d;
      req_we_q   <= req_we_d;
      req_sel_q  <= req_sel_d;
      req_dati_q <= req_dati_d;
   end
endmodule

// File: tb/tb_wb_txn_monitor.sv
// Directed bench for wb_txn_monitor: default instance plus a small-parameter
// instance (CNT_W=2, DEPTH=2, TIMEOUT=4) sharing the same bus stimulus.
module tb_wb_txn_monitor;
   logic        clk = 1'b0;
   logic        rst, cyc, stb, we, ack, ready, clr;
   logic [25:0] addr;
   logic [3:0]  sel;
   logic [31:0] dati, dato;
   logic [2:0]  cti;

   logic        valid, t_we, t_last, e_tmo, e_stb, e_pro, e_ovf;
   logic [25:0] t_addr;
   logic [3:0]  t_sel;
   logic [31:0] t_data;
   logic [15:0] rd_cnt, wr_cnt;

   logic        s_valid, s_we, s_last, s_tmo, s_stb, s_pro, s_ovf;
   logic [25:0] s_addr;
   logic [3:0]  s_sel;
   logic [31:0] s_data;
   logic [1:0]  s_rd, s_wr;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   wb_txn_monitor u_dut (
      .wb_clk(clk), .wb_rst(rst), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
      .wb_addr(addr), .wb_sel(sel), .wb_dati(dati), .wb_dato(dato),
      .wb_ack(ack), .wb_cti(cti), .txn_valid(valid), .txn_ready(ready),
      .txn_addr(t_addr), .txn_we(t_we), .txn_sel(t_sel), .txn_data(t_data),
      .txn_last(t_last), .rd_count(rd_cnt), .wr_count(wr_cnt), .err_clr(clr),
      .err_timeout(e_tmo), .err_stable(e_stb), .err_proto(e_pro), .err_overflow(e_ovf)
   );

   wb_txn_monitor #(.APP_AW(26), .DW(32), .DEPTH(2), .CNT_W(2), .TIMEOUT(4)) u_sat (
      .wb_clk(clk), .wb_rst(rst), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we),
      .wb_addr(addr), .wb_sel(sel), .wb_dati(dati), .wb_dato(dato),
      .wb_ack(ack), .wb_cti(cti), .txn_valid(s_valid), .txn_ready(ready),
      .txn_addr(s_addr), .txn_we(s_we), .txn_sel(s_sel), .txn_data(s_data),
      .txn_last(s_last), .rd_count(s_rd), .wr_count(s_wr), .err_clr(clr),
      .err_timeout(s_tmo), .err_stable(s_stb), .err_proto(s_pro), .err_overflow(s_ovf)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      cyc = 0; stb = 0; ack = 0; we = 0; cti = 3'b000;
   endtask

   task automatic pop_one();
      ready = 1; tick(); ready = 0;
   endtask

   task automatic do_reset();
      idle_bus(); rst = 1; tick(); rst = 0;
   endtask

   task automatic clear_errs();
      clr = 1; tick(); clr = 0;
   endtask

   initial begin
      rst = 1; ready = 0; clr = 0; addr = '0; sel = 4'hF; dati = '0; dato = '0;
      idle_bus();
      tick(); tick();
      check("rst_valid", valid, 0);
      check("rst_addr", t_addr, 0);
      check("rst_rd", rd_cnt, 0);
      check("rst_wr", wr_cnt, 0);
      check("rst_errs", {e_tmo, e_stb, e_pro, e_ovf}, 0);
      rst = 0;

      // Single write, ack after three wait cycles.
      cyc = 1; stb = 1; we = 1; addr = 26'h0000100; dati = 32'hDEADBEEF; sel = 4'hF;
      repeat (3) tick();
      check("wr_wait_valid", valid, 0);
      ack = 1; tick(); idle_bus();
      check("wr_valid", valid, 1);
      check("wr_addr", t_addr, 26'h100);
      check("wr_we", t_we, 1);
      check("wr_sel", t_sel, 4'hF);
      check("wr_data", t_data, 32'hDEADBEEF);
      check("wr_last", t_last, 1);
      check("wr_count", wr_cnt, 1);
      check("wr_rd_count", rd_cnt, 0);
      check("wr_errs", {e_tmo, e_stb, e_pro, e_ovf}, 0);
      check("sat_tmo_edge", s_tmo, 0);
      pop_one();
      check("wr_popped", valid, 0);

      // Four-beat incrementing read burst.
      for (int i = 0; i < 4; i++) begin
         cyc = 1; stb = 1; we = 0; ack = 1;
         addr = 26'h200 + 26'(4 * i); dato = 32'h11 * (i + 1);
         cti = (i == 3) ? 3'b111 : 3'b010;
         tick();
      end
      idle_bus();
      check("bu_rd_count", rd_cnt, 4);
      check("bu_proto", e_pro, 0);
      for (int i = 0; i < 4; i++) begin
         check("bu_valid", valid, 1);
         check("bu_addr", t_addr, 26'h200 + 26'(4 * i));
         check("bu_data", t_data, 32'h11 * (i + 1));
         check("bu_last", t_last, (i == 3) ? 1 : 0);
         check("bu_we", t_we, 0);
         pop_one();
      end
      check("bu_empty", valid, 0);

      // Overflow: nine single writes with no consumer.
      do_reset();
      for (int i = 0; i < 9; i++) begin
         cyc = 1; stb = 1; we = 1; ack = 1; cti = 3'b000;
         addr = 26'h400 + 26'(4 * i); dati = 32'hA0 + i;
         tick();
         if (i == 7) check("ov_full_no_err", e_ovf, 0);
      end
      idle_bus();
      check("ov_err", e_ovf, 1);
      check("ov_wr_count", wr_cnt, 9);
      check("sat_wr_count", s_wr, 3);
      check("sat_ovf", s_ovf, 1);
      check("ov_head_addr", t_addr, 26'h400);
      check("ov_head_data", t_data, 32'hA0);
      clear_errs();
      check("ov_clr", e_ovf, 0);
      // Push into a full FIFO while popping is accepted.
      cyc = 1; stb = 1; we = 1; ack = 1; addr = 26'h500; dati = 32'hB5; ready = 1;
      tick(); ready = 0; idle_bus();
      check("ov_pushpop_err", e_ovf, 0);
      check("ov_pushpop_head", t_addr, 26'h404);
      repeat (7) pop_one();
      check("ov_tail_addr", t_addr, 26'h500);
      check("ov_tail_data", t_data, 32'hB5);
      pop_one();
      check("ov_drained", valid, 0);

      // Ack timeout.
      do_reset();
      cyc = 1; stb = 1; we = 0; addr = 26'h600;
      repeat (255) tick();
      check("tmo_255", e_tmo, 0);
      tick();
      check("tmo_256", e_tmo, 1);
      check("tmo_stable", e_stb, 0);
      idle_bus(); tick();
      check("tmo_sticky", e_tmo, 1);
      clear_errs();
      check("tmo_clr", e_tmo, 0);

      // Request changes while waiting for ack.
      cyc = 1; stb = 1; we = 0; addr = 26'h300;
      tick();
      check("stb_before", e_stb, 0);
      addr = 26'h304; tick();
      check("stb_err", e_stb, 1);
      ack = 1; tick(); idle_bus();
      check("stb_proto", e_pro, 0);
      // Strobe without cycle.
      stb = 1; tick(); stb = 0;
      check("proto_nocyc", e_pro, 1);
      clear_errs();
      check("proto_clr", e_pro, 0);
      check("stb_clr", e_stb, 0);
      // Error event wins over a simultaneous clear.
      stb = 1; clr = 1; tick(); stb = 0; clr = 0;
      check("proto_clr_race", e_pro, 1);
      clear_errs();
      // Reserved cycle type on a beat.
      cyc = 1; stb = 1; ack = 1; cti = 3'b001; addr = 26'h340; tick(); idle_bus();
      check("proto_cti", e_pro, 1);

      // Reset in the middle of a burst with three entries queued.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cyc = 1; stb = 1; we = 0; ack = 1; cti = 3'b010;
         addr = 26'h700 + 26'(4 * i); dato = 32'h70 + i;
         tick();
      end
      check("mr_queued", valid, 1);
      addr = 26'h70C; rst = 1; tick(); rst = 0;
      check("mr_valid", valid, 0);
      check("mr_rd", rd_cnt, 0);
      check("mr_wr", wr_cnt, 0);
      addr = 26'h710; dato = 32'h55; cti = 3'b111; tick(); idle_bus();
      check("mr_resume_valid", valid, 1);
      check("mr_resume_addr", t_addr, 26'h710);
      check("mr_resume_last", t_last, 1);
      check("mr_resume_data", t_data, 32'h55);
      check("mr_resume_rd", rd_cnt, 1);
      check("mr_resume_proto", e_pro, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
